// File: rtl/clkgate_ctrl.sv
// clkgate_ctrl: clock-gate sequencer for N_CH downstream clock gate cells.
// Each channel walks OFF -> WAKE -> ON -> SLEEP -> OFF. A round-robin arbiter
// admits one channel at a time into WAKE so that clock-tree inrush is bounded.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   req[N_CH]    per-channel level request for a running clock
//   idle_thresh  req-low cycles tolerated in ON before sleeping (quasi-static)
//   force_on     debug override, ORs all ones onto clk_en after the register
//   clk_en[N_CH] enable to each clock gate cell
//   ack[N_CH]    gated clock is stable and usable
//   busy         some channel is in WAKE or SLEEP

// Per-channel sequencer. grant is only ever raised while pending is high.
module clkgate_lane #(
  parameter int WAKE_CYCLES  = 4,
  parameter int SLEEP_CYCLES = 2,
  parameter int W_IDLE       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              grant,
  input  logic [W_IDLE-1:0] idle_thresh,
  output logic              pending,
  output logic              wake_hold,
  output logic              busy_nxt,
  output logic              clk_en_q,
  output logic              ack_q
);
  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_SLEEP} cg_state_e;

  localparam logic [3:0] WAKE_LAST  = 4'(WAKE_CYCLES - 1);
  localparam logic [3:0] SLEEP_LAST = 4'(SLEEP_CYCLES - 1);

  cg_state_e         st, st_n;
  logic [3:0]        phase, phase_n;
  logic [W_IDLE-1:0] idle, idle_n;

  always_comb begin
    st_n    = st;
    phase_n = phase;
    idle_n  = idle;
    case (st)
      S_OFF: if (grant) begin
        st_n    = S_WAKE;
        phase_n = '0;
      end
      S_WAKE: if (phase == WAKE_LAST) begin
        st_n    = S_ON;
        phase_n = '0;
        idle_n  = '0;
      end else begin
        phase_n = phase + 4'd1;
      end
      S_ON: if (req) begin
        idle_n = '0;
      end else if (idle == idle_thresh) begin
        st_n    = S_SLEEP;
        phase_n = '0;
        idle_n  = '0;
      end else if (idle != '1) begin
        idle_n = idle + W_IDLE'(1);
      end
      S_SLEEP: if (phase == SLEEP_LAST) begin
        st_n    = S_OFF;
        phase_n = '0;
      end else begin
        phase_n = phase + 4'd1;
      end
      default: st_n = S_OFF;
    endcase
  end

  assign pending   = (st == S_OFF) && req;
  // Slot is released on the last WAKE cycle so the next grant lands on the
  // same edge this channel moves to ON: back-to-back wakes, no gap.
  assign wake_hold = (st == S_WAKE) && (phase != WAKE_LAST);
  assign busy_nxt  = (st_n == S_WAKE) || (st_n == S_SLEEP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= S_OFF;
      phase    <= '0;
      idle     <= '0;
      clk_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      st       <= st_n;
      phase    <= phase_n;
      idle     <= idle_n;
      clk_en_q <= (st_n != S_OFF);
      ack_q    <= (st_n == S_ON);
    end
  end
endmodule

module clkgate_ctrl #(
  parameter int N_CH         = 4,
  parameter int WAKE_CYCLES  = 4,
  parameter int SLEEP_CYCLES = 2,
  parameter int W_IDLE       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic [W_IDLE-1:0] idle_thresh,
  input  logic              force_on,
  output logic [N_CH-1:0]   clk_en,
  output logic [N_CH-1:0]   ack,
  output logic              busy
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] pending, wake_hold, busy_nxt, grant, clk_en_q;
  logic [PW-1:0]   ptr, gnt_idx;
  logic            found;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    clkgate_lane #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .SLEEP_CYCLES(SLEEP_CYCLES),
      .W_IDLE      (W_IDLE)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req[g]),
      .grant      (grant[g]),
      .idle_thresh(idle_thresh),
      .pending    (pending[g]),
      .wake_hold  (wake_hold[g]),
      .busy_nxt   (busy_nxt[g]),
      .clk_en_q   (clk_en_q[g]),
      .ack_q      (ack[g])
    );
  end

  // Round-robin search starting at ptr (one past the last grant).
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (wake_hold == '0) begin
      for (int i = 0; i < N_CH; i++) begin
        idx = (int'(ptr) + i) % N_CH;
        if (!found && pending[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      busy <= 1'b0;
    end else begin
      busy <= |busy_nxt;
      if (found) ptr <= (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Debug override sits after the register so FSM, ack and busy are untouched.
  assign clk_en = clk_en_q | {N_CH{force_on}};
endmodule
